cordic_sincos_pipe: RTL and testbench

//  Parametrised, fully pipelined CORDIC rotator: one sample per clock, returns sine and cosine.
//  The phase comes from an external angle or an internal phase accumulator (DDS mode).

---
 rtl/cordic_pkg.sv | 26 ++
 rtl/cordic_stage.sv | 66 ++++++
 rtl/cordic_sincos_pipe.sv | 143 ++++++++++++++
 tb/tb_cordic_sincos_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC sine/cosine pipeline: arctangent table,
// rounding helper and the CORDIC gain used to size the start vector.
package cordic_pkg;

    localparam int CORDIC_GAIN_Q16 = 107922;

    // atan(2^-i) as a fraction of the full circle, full circle = 2^32
    localparam logic [31:0] ATAN_LUT [30] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001
    };

    function automatic logic [31:0] atan_z(input int i, input int z_sz);
        logic [32:0] r;
        if (z_sz >= 32) return ATAN_LUT[5'(i)];
        r = {1'b0, ATAN_LUT[5'(i)]} + (33'd1 << (31 - z_sz));
        return 32'(r >> (32 - z_sz));
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; the whole stage holds while en is low.
module cordic_stage #(
    parameter int              W     = 18,
    parameter int              Z_SZ  = 16,
    parameter int              SHIFT = 0,
    parameter logic [Z_SZ-1:0] ATAN  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                v_in,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic [Z_SZ-1:0]     z_in,
    output logic                v_out,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic [Z_SZ-1:0]     z_out
);

    logic signed [W-1:0] x_sh, y_sh, x_d, y_d, x_q, y_q;
    logic [Z_SZ-1:0]     z_d, z_q;
    logic                v_d, v_q;

    always_comb begin
        x_sh = x_in >>> SHIFT;
        y_sh = y_in >>> SHIFT;
        x_d  = x_q;
        y_d  = y_q;
        z_d  = z_q;
        v_d  = v_q;
        if (en) begin
            v_d = v_in;
            // negative residual angle: rotate clockwise
            if (z_in[Z_SZ-1]) begin
                x_d = x_in + y_sh;
                y_d = y_in - x_sh;
                z_d = z_in + ATAN;
            end else begin
                x_d = x_in - y_sh;
                y_d = y_in + x_sh;
                z_d = z_in - ATAN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            v_q <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            v_q <= v_d;
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign z_out = z_q;
    assign v_out = v_q;

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined CORDIC sine/cosine generator with optional DDS phase accumulator
// and a single advance signal that stalls the whole pipe when the output is blocked.
module cordic_sincos_pipe import cordic_pkg::*; #(
    parameter int XY_SZ  = 16,
    parameter int Z_SZ   = 16,
    parameter int STG    = 14,
    parameter int ACC_SZ = 32,
    // start magnitude rounded up so the gain-scaled peak lands on full scale
    parameter int AMP    = int'(((64'(2**(XY_SZ-1) - 1) << 16) + 64'(CORDIC_GAIN_Q16) - 64'd1)
                                / 64'(CORDIC_GAIN_Q16))
) (
    input  logic                    CLK_100MHZ,
    input  logic                    RST_N,
    input  logic                    mode,
    input  logic [ACC_SZ-1:0]       freq_word,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Z_SZ-1:0]         in_angle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [XY_SZ-1:0] sin_out,
    output logic signed [XY_SZ-1:0] cos_out
);

    localparam int W = XY_SZ + 2;
    localparam logic signed [W-1:0] AMP_W = W'(AMP);
    localparam logic signed [W-1:0] MAXV  = W'((2**(XY_SZ-1)) - 1);

    function automatic logic signed [XY_SZ-1:0] sat(input logic signed [W-1:0] v);
        if (v > MAXV)  return XY_SZ'(MAXV);
        if (v < -MAXV) return XY_SZ'(-MAXV);
        return XY_SZ'(v);
    endfunction

    logic                    adv, accept;
    logic [Z_SZ-1:0]         angle;
    logic [ACC_SZ-1:0]       acc_d, acc_q;
    logic signed [W-1:0]     x0_d, x0_q, y0_d, y0_q;
    logic [Z_SZ-1:0]         z0_d, z0_q;
    logic                    v0_d, v0_q;
    logic signed [XY_SZ-1:0] sin_d, sin_q, cos_d, cos_q;
    logic                    ov_d, ov_q;

    logic signed [W-1:0]     xs [0:STG];
    logic signed [W-1:0]     ys [0:STG];
    logic [Z_SZ-1:0]         zs [0:STG];
    logic                    vs [0:STG];
    logic                    z_final_unused;

    always_comb begin
        adv    = !ov_q || out_ready;
        accept = in_valid && adv;
        angle  = mode ? acc_q[ACC_SZ-1 -: Z_SZ] : in_angle;
        acc_d  = accept ? acc_q + freq_word : acc_q;
        x0_d   = x0_q;
        y0_d   = y0_q;
        z0_d   = z0_q;
        v0_d   = v0_q;
        sin_d  = sin_q;
        cos_d  = cos_q;
        ov_d   = ov_q;
        if (adv) begin
            v0_d = in_valid;
            // fold the angle into +/-90 deg so the micro-rotations can converge
            case (angle[Z_SZ-1 -: 2])
                2'b01: begin
                    x0_d = '0;
                    y0_d = AMP_W;
                    z0_d = {2'b00, angle[Z_SZ-3:0]};
                end
                2'b10: begin
                    x0_d = '0;
                    y0_d = -AMP_W;
                    z0_d = {2'b11, angle[Z_SZ-3:0]};
                end
                default: begin
                    x0_d = AMP_W;
                    y0_d = '0;
                    z0_d = angle;
                end
            endcase
            sin_d = sat(ys[STG]);
            cos_d = sat(xs[STG]);
            ov_d  = vs[STG];
        end
    end

    always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            acc_q <= '0;
            x0_q  <= '0;
            y0_q  <= '0;
            z0_q  <= '0;
            v0_q  <= 1'b0;
            sin_q <= '0;
            cos_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            x0_q  <= x0_d;
            y0_q  <= y0_d;
            z0_q  <= z0_d;
            v0_q  <= v0_d;
            sin_q <= sin_d;
            cos_q <= cos_d;
            ov_q  <= ov_d;
        end
    end

    assign xs[0] = x0_q;
    assign ys[0] = y0_q;
    assign zs[0] = z0_q;
    assign vs[0] = v0_q;

    for (genvar gi = 0; gi < STG; gi++) begin : g_stage
        cordic_stage #(
            .W     (W),
            .Z_SZ  (Z_SZ),
            .SHIFT (gi),
            .ATAN  (Z_SZ'(atan_z(gi, Z_SZ)))
        ) u_stage (
            .clk   (CLK_100MHZ),
            .rst_n (RST_N),
            .en    (adv),
            .v_in  (vs[gi]),
            .x_in  (xs[gi]),
            .y_in  (ys[gi]),
            .z_in  (zs[gi]),
            .v_out (vs[gi+1]),
            .x_out (xs[gi+1]),
            .y_out (ys[gi+1]),
            .z_out (zs[gi+1])
        );
    end

    assign z_final_unused = ^zs[STG];

    assign in_ready  = adv;
    assign out_valid = ov_q;
    assign sin_out   = sin_q;
    assign cos_out   = cos_q;

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Directed self-checking bench for cordic_sincos_pipe: latency, quadrant points,
// DDS sweep, random back-pressure, bubbles and asynchronous reset.
module tb_cordic_sincos_pipe;

    localparam int N_MAX = 1024;
    localparam int TOL   = 8;
    localparam int LAT   = 16;
    localparam int FS    = 32767;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               mode      = 1'b0;
    logic [31:0]        freq_word = '0;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [15:0]        in_angle  = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;

    int checks   = 0;
    int failures = 0;
    int in_ang  [N_MAX];
    int acc_cyc [N_MAX];
    int cap_sin [N_MAX];
    int cap_cos [N_MAX];
    int cap_cyc [N_MAX];
    int ref_sin [N_MAX];
    int ref_cos [N_MAX];

    int sin_tab [8] = '{0, 23170, FS, 23170, 0, -23170, -FS, -23170};
    int cos_tab [8] = '{FS, 23170, 0, -23170, -FS, -23170, 0, 23170};

    always #5 clk = ~clk;

    cordic_sincos_pipe dut (
        .CLK_100MHZ (clk),
        .RST_N      (rst_n),
        .mode       (mode),
        .freq_word  (freq_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_angle   (in_angle),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sin_out    (sin_out),
        .cos_out    (cos_out)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        diff = obs - exp;
        checks++;
        if (diff > tol || diff < -tol) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives n samples (angles from in_ang in mode 0), collects n outputs in order.
    task automatic run_stream(input int n, input bit rand_ready, input bit gap);
        int k_in, k_out, t;
        bit hold_pend;
        int hs, hc;
        k_in = 0; k_out = 0; t = 0; hold_pend = 0; hs = 0; hc = 0;
        while (k_out < n && t < 5000) begin
            @(negedge clk);
            if (hold_pend) begin
                check("hold_valid", int'(out_valid), 1, 0);
                check("hold_sin", int'(sin_out), hs, 0);
                check("hold_cos", int'(cos_out), hc, 0);
            end
            hold_pend = 0;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (k_in < n) && (!gap || (t % 2 == 0));
            in_angle  = 16'(in_ang[k_in]);
            #1;
            if (in_valid && in_ready) begin
                acc_cyc[k_in] = t;
                k_in++;
            end
            if (out_valid && out_ready) begin
                cap_sin[k_out] = int'(sin_out);
                cap_cos[k_out] = int'(cos_out);
                cap_cyc[k_out] = t;
                if (n <= 8)
                    $display("out[%0d] t=%0d sin=%0d cos=%0d", k_out, t, sin_out, cos_out);
                k_out++;
            end else if (out_valid) begin
                hold_pend = 1;
                hs = int'(sin_out);
                hc = int'(cos_out);
            end
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", k_out, n, 0);
    endtask

    initial begin
        int mx, neg_fs;

        // reset state
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_sin", int'(sin_out), 0, 0);
        check("rst_cos", int'(cos_out), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1, 0);

        // 1: single angle 0, latency
        in_ang[0] = 16'h0000;
        run_stream(1, 0, 0);
        check("t1_latency", cap_cyc[0] - acc_cyc[0], LAT, 0);
        check("t1_cos", cap_cos[0], FS, TOL);
        check("t1_sin", cap_sin[0], 0, TOL);

        // 2: quadrant points back-to-back
        in_ang[0] = 16'h4000; in_ang[1] = 16'h8000; in_ang[2] = 16'hC000; in_ang[3] = 16'h2000;
        run_stream(4, 0, 0);
        check("t2_sin0", cap_sin[0], FS, TOL);     check("t2_cos0", cap_cos[0], 0, TOL);
        check("t2_sin1", cap_sin[1], 0, TOL);      check("t2_cos1", cap_cos[1], -FS, TOL);
        check("t2_sin2", cap_sin[2], -FS, TOL);    check("t2_cos2", cap_cos[2], 0, TOL);
        check("t2_sin3", cap_sin[3], 23170, TOL);  check("t2_cos3", cap_cos[3], 23170, TOL);
        for (int k = 1; k < 4; k++)
            check("t2_consecutive", cap_cyc[k] - cap_cyc[0], k, 0);

        // 3: DDS sweep, period 256
        do_reset();
        mode = 1'b1;
        freq_word = 32'h0100_0000;
        run_stream(300, 0, 0);
        for (int k = 0; k < 8; k++) begin
            check("t3_sin_pt", cap_sin[k*32], sin_tab[k], TOL);
            check("t3_cos_pt", cap_cos[k*32], cos_tab[k], TOL);
        end
        for (int k = 0; k < 44; k++)
            check("t3_period", cap_sin[k+256], cap_sin[k], 0);
        mx = -100000; neg_fs = 0;
        for (int k = 0; k < 300; k++) begin
            if (cap_sin[k] > mx) mx = cap_sin[k];
            if (cap_sin[k] == -32768 || cap_cos[k] == -32768) neg_fs++;
        end
        check("t3_peak", mx, FS, TOL);
        check("t3_no_neg_fs", neg_fs, 0, 0);
        check("t3_throughput", cap_cyc[299] - cap_cyc[0], 299, 0);

        // 5: bubbles in mode 1, acc advances only on accepts
        do_reset();
        run_stream(4, 0, 1);
        check("t5_sin0", cap_sin[0], 0, TOL);     check("t5_cos0", cap_cos[0], FS, TOL);
        check("t5_sin1", cap_sin[1], 804, TOL);   check("t5_cos1", cap_cos[1], 32757, TOL);
        check("t5_sin2", cap_sin[2], 1608, TOL);  check("t5_cos2", cap_cos[2], 32728, TOL);
        check("t5_sin3", cap_sin[3], 2410, TOL);  check("t5_cos3", cap_cos[3], 32678, TOL);
        for (int k = 0; k < 4; k++)
            check("t5_latency", cap_cyc[k] - acc_cyc[k], LAT, 0);
        for (int k = 1; k < 4; k++)
            check("t5_spacing", cap_cyc[k] - cap_cyc[k-1], 2, 0);
        mode = 1'b0;
        freq_word = '0;

        // 4: random back-pressure must not change the output sequence
        for (int k = 0; k < 1000; k++) in_ang[k] = (k * 64) % 65536;
        run_stream(1000, 0, 0);
        for (int k = 0; k < 1000; k++) begin
            ref_sin[k] = cap_sin[k];
            ref_cos[k] = cap_cos[k];
        end
        run_stream(1000, 1, 0);
        for (int k = 0; k < 1000; k++) begin
            check("t4_sin_seq", cap_sin[k], ref_sin[k], 0);
            check("t4_cos_seq", cap_cos[k], ref_cos[k], 0);
        end

        // 6: asynchronous reset mid-stream
        in_angle = 16'h2000;
        in_valid = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("t6_pre_valid", int'(out_valid), 1, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(out_valid), 0, 0);
        check("t6_rst_sin", int'(sin_out), 0, 0);
        check("t6_rst_cos", int'(cos_out), 0, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_ang[0] = 16'h4000;
        run_stream(1, 0, 0);
        check("t6_first_sin", cap_sin[0], FS, TOL);
        check("t6_first_cos", cap_cos[0], 0, TOL);
        check("t6_latency", cap_cyc[0] - acc_cyc[0], LAT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
